// File: rtl/fma16_sched_pkg.sv
// Shared definitions for the fma16 scheduler slice.
// Holds the per-requester control field layout, flag bit indices, rounding-mode
// encodings and the packed payload structs of the two pipeline stages.
package fma16_sched_pkg;

    // Control word layout: {mul, add, negp, negz, roundmode[1:0]}
    localparam int unsigned CtlW    = 6;
    localparam int unsigned CtlMul  = 5;
    localparam int unsigned CtlAdd  = 4;
    localparam int unsigned CtlNegp = 3;
    localparam int unsigned CtlNegz = 2;
    localparam int unsigned CtlRmLo = 0;

    // Exception flag bit positions: {NV, OF, UF, NX}
    localparam int unsigned FlagNv = 3;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagUf = 1;
    localparam int unsigned FlagNx = 0;

    localparam logic [1:0] RmRz  = 2'd0;  // toward zero
    localparam logic [1:0] RmRne = 2'd1;  // nearest, ties to even
    localparam logic [1:0] RmRdn = 2'd2;  // toward -inf
    localparam logic [1:0] RmRup = 2'd3;  // toward +inf

    typedef struct packed {
        logic [15:0]     x;
        logic [15:0]     y;
        logic [15:0]     z;
        logic [CtlW-1:0] ctl;
    } s1_data_t;

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  flags;
    } s2_data_t;

endpackage

// File: rtl/fma16.sv
// Combinational half-precision fused multiply-add: result = +/-(x*y) +/- z.
// Ports: x, y, z operands; mul=0 treats y as 1.0; add=0 treats z as zero;
// negp/negz negate product/addend; roundmode selects rounding;
// result is the rounded value, flags is {NV, OF, UF, NX}.
// The sum is formed exactly in an 84-bit fixed-point frame (lsb = 2^-48) and
// rounded once, so no intermediate rounding can occur.
module fma16
    import fma16_sched_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam int W = 84;

    logic [15:0]  ye, ze;
    logic         sp, sz, sign;
    logic [4:0]   ex, ey, ez;
    logic [10:0]  mx, my, mz;
    logic [21:0]  prod;
    logic [W-1:0] pm, zm, mag, mask;
    logic [11:0]  q, qr;
    logic         guard, sticky, inexact, inc, tiny;
    logic         x_nan, y_nan, z_nan, any_snan;
    logic         x_inf, y_inf, z_inf, x_zero, y_zero, inv_mul, inv_add;
    int           lead, k, bexp;

    assign ye = mul ? y : 16'h3C00;
    assign sp = x[15] ^ ye[15] ^ negp;
    // A disabled addend is a zero carrying the product sign, so x*y keeps its sign.
    assign ze = add ? z : {sp ^ negz, 15'h0};
    assign sz = ze[15] ^ negz;

    // Subnormals share the exponent of the smallest normal, without hidden bit.
    assign ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    assign ey = (ye[14:10] == 5'd0) ? 5'd1 : ye[14:10];
    assign ez = (ze[14:10] == 5'd0) ? 5'd1 : ze[14:10];
    assign mx = {|x[14:10], x[9:0]};
    assign my = {|ye[14:10], ye[9:0]};
    assign mz = {|ze[14:10], ze[9:0]};

    assign x_nan    = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    assign y_nan    = (ye[14:10] == 5'h1F) && (ye[9:0] != 10'd0);
    assign z_nan    = (ze[14:10] == 5'h1F) && (ze[9:0] != 10'd0);
    assign any_snan = (x_nan & ~x[9]) | (y_nan & ~ye[9]) | (z_nan & ~ze[9]);
    assign x_inf    = (x[14:0] == 15'h7C00);
    assign y_inf    = (ye[14:0] == 15'h7C00);
    assign z_inf    = (ze[14:0] == 15'h7C00);
    assign x_zero   = (x[14:0] == 15'h0);
    assign y_zero   = (ye[14:0] == 15'h0);
    assign inv_mul  = (x_inf & y_zero) | (x_zero & y_inf);
    assign inv_add  = (x_inf | y_inf) & z_inf & (sp != sz);

    always_comb begin
        prod = 22'(mx) * 22'(my);
        pm   = W'(prod) << (6'(ex) + 6'(ey) - 6'd2);
        zm   = W'(mz) << (6'(ez) + 6'd23);

        if (sp == sz) begin
            mag  = pm + zm;
            sign = sp;
        end else if (pm >= zm) begin
            mag  = pm - zm;
            sign = sp;
        end else begin
            mag  = zm - pm;
            sign = sz;
        end
        // Exact cancellation gives +0, except -0 when rounding down.
        if (mag == '0) sign = (sp == sz) ? sp : (roundmode == RmRdn);

        lead = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = i;
        end
        // Keep 11 significant bits, but never below the subnormal lsb (2^-24).
        k       = (lead < 34) ? 24 : lead - 10;
        q       = 12'(mag >> k);
        guard   = mag[k-1];
        mask    = {W{1'b1}} << (k - 1);
        sticky  = |(mag & ~mask);
        inexact = guard | sticky;

        unique case (roundmode)
            RmRne:   inc = guard & (sticky | q[0]);
            RmRdn:   inc = inexact & sign;
            RmRup:   inc = inexact & ~sign;
            default: inc = 1'b0;
        endcase

        qr   = q + 12'(inc);
        bexp = qr[11] ? k - 22 : (qr[10] ? k - 23 : 0);
        tiny = (bexp == 0);

        result         = {sign, 5'(bexp), qr[9:0]};
        flags          = '0;
        flags[FlagNx]  = inexact;
        flags[FlagUf]  = inexact & tiny;

        if (bexp >= 31) begin
            flags[FlagOf] = 1'b1;
            flags[FlagNx] = 1'b1;
            // Rounding away from the overflow direction saturates to max finite.
            if ((roundmode == RmRz) || ((roundmode == RmRdn) && !sign) ||
                ((roundmode == RmRup) && sign)) begin
                result = {sign, 15'h7BFF};
            end else begin
                result = {sign, 15'h7C00};
            end
        end

        if (x_nan | y_nan | z_nan | inv_mul | inv_add) begin
            result        = 16'h7E00;
            flags         = '0;
            flags[FlagNv] = any_snan | inv_mul | inv_add;
        end else if (x_inf | y_inf) begin
            result = {sp, 15'h7C00};
            flags  = '0;
        end else if (z_inf) begin
            result = {sz, 15'h7C00};
            flags  = '0;
        end
    end

endmodule

// File: rtl/fma16_rr_arb.sv
// Round-robin arbiter for the fma16 scheduler.
// Ports: clk/reset_n; req_valid per requester; advance = stage 1 can load;
// req_ready one-hot accept; grant_valid/grant_id describe the accepted request.
// The pointer holds the last accepted index and moves only on an accept.
module fma16_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic [NREQ-1:0] req_ready,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id
);
    logic [IDW-1:0] last_q, last_d;
    logic           found;
    int             idx;

    always_comb begin
        found    = 1'b0;
        grant_id = last_q;
        idx      = 0;
        for (int off = 1; off <= int'(NREQ); off++) begin
            idx = (int'(last_q) + off) % int'(NREQ);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        grant_valid = found & advance;
        req_ready   = '0;
        if (grant_valid) req_ready[grant_id] = 1'b1;
        last_d = grant_valid ? grant_id : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= IDW'(NREQ - 1);  // requester 0 wins first
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fma16_sched.sv
// Shared-issue scheduler: round-robin accepts requests from NREQ requesters,
// runs them through one fma16 between an operand register and a result
// register, and returns tagged responses in acceptance order.
// Ports: req_valid/req_ready/req_x/req_y/req_z/req_ctl per-requester request
// channel (packed slices); rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags
// response channel; clear_flags/sticky_flags per-requester sticky exceptions.
module fma16_sched
    import fma16_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [CtlW*NREQ-1:0] req_ctl,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    input  logic [NREQ-1:0]      clear_flags,
    output logic [4*NREQ-1:0]    sticky_flags
);
    logic             s1_load, s2_load, grant_valid;
    logic [IDW-1:0]   grant_id;
    logic             s1_valid_q, s2_valid_q;
    logic [IDW-1:0]   s1_id_q, s2_id_q;
    s1_data_t         s1_q, s1_d;
    s2_data_t         s2_q;
    logic [15:0]      fma_result;
    logic [3:0]       fma_flags;
    logic [4*NREQ-1:0] sticky_q, sticky_d;

    // A stage loads when empty or when the stage after it drains this cycle.
    assign s2_load = ~s2_valid_q | rsp_ready;
    assign s1_load = ~s1_valid_q | s2_load;

    fma16_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .advance     (s1_load),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        s1_d.x   = req_x[int'(grant_id)*16 +: 16];
        s1_d.y   = req_y[int'(grant_id)*16 +: 16];
        s1_d.z   = req_z[int'(grant_id)*16 +: 16];
        s1_d.ctl = req_ctl[int'(grant_id)*CtlW +: CtlW];
    end

    fma16 u_fma16 (
        .x         (s1_q.x),
        .y         (s1_q.y),
        .z         (s1_q.z),
        .mul       (s1_q.ctl[CtlMul]),
        .add       (s1_q.ctl[CtlAdd]),
        .negp      (s1_q.ctl[CtlNegp]),
        .negz      (s1_q.ctl[CtlNegz]),
        .roundmode (s1_q.ctl[CtlRmLo +: 2]),
        .result    (fma_result),
        .flags     (fma_flags)
    );

    // Clear wipes the old state; a same-cycle response still deposits its flags.
    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (clear_flags[i]) sticky_d[4*i +: 4] = 4'b0;
            if (s2_valid_q && rsp_ready && (int'(s2_id_q) == i)) begin
                sticky_d[4*i +: 4] = sticky_d[4*i +: 4] | s2_q.flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_q       <= '0;
            sticky_q   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= grant_valid;
                if (grant_valid) begin
                    s1_id_q <= grant_id;
                    s1_q    <= s1_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_id_q <= s1_id_q;
                    s2_q    <= '{result: fma_result, flags: fma_flags};
                end
            end
            sticky_q <= sticky_d;
        end
    end

    assign rsp_valid    = s2_valid_q;
    assign rsp_id       = s2_id_q;
    assign rsp_result   = s2_q.result;
    assign rsp_flags    = s2_q.flags;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched: a 2-requester instance for the main tests
// and a 3-requester instance for the fairness test.
module tb_fma16_sched;
    import fma16_sched_pkg::*;

    localparam logic [5:0] CtlFma  = {4'b1100, RmRne};  // x*y+z
    localparam logic [5:0] CtlMulO = {4'b1000, RmRne};  // x*y
    localparam logic [5:0] CtlPass = {4'b0000, RmRne};  // x*1+0 = x

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_ready, clear_flags;
    logic [31:0] req_x, req_y, req_z;
    logic [11:0] req_ctl;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [7:0]  sticky_flags;

    logic [2:0]  req_valid3, req_ready3, clear_flags3;
    logic [47:0] req_x3, req_y3, req_z3;
    logic [17:0] req_ctl3;
    logic        rsp_valid3, rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [15:0] rsp_result3;
    logic [3:0]  rsp_flags3;
    logic [11:0] sticky_flags3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fma16_sched #(.NREQ(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_z        (req_z),
        .req_ctl      (req_ctl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .clear_flags  (clear_flags),
        .sticky_flags (sticky_flags)
    );

    fma16_sched #(.NREQ(3)) dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid3),
        .req_ready    (req_ready3),
        .req_x        (req_x3),
        .req_y        (req_y3),
        .req_z        (req_z3),
        .req_ctl      (req_ctl3),
        .rsp_valid    (rsp_valid3),
        .rsp_ready    (rsp_ready3),
        .rsp_id       (rsp_id3),
        .rsp_result   (rsp_result3),
        .rsp_flags    (rsp_flags3),
        .clear_flags  (clear_flags3),
        .sticky_flags (sticky_flags3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic [5:0] ctl);
        req_x[i*16 +: 16] = x;
        req_y[i*16 +: 16] = y;
        req_z[i*16 +: 16] = z;
        req_ctl[i*6 +: 6] = ctl;
    endtask

    logic [15:0] tbl [8] = '{16'h4000, 16'h4100, 16'h4200, 16'h4300,
                             16'h4400, 16'h4500, 16'h4600, 16'h4700};
    logic [15:0] bp  [3] = '{16'h4800, 16'h4900, 16'h4A00};
    int          g3  [7] = '{0, 2, 0, 2, 0, 1, 2};
    int          cnt [2];
    int          n;
    logic        v1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_x = '0; req_y = '0; req_z = '0; req_ctl = '0;
        clear_flags = '0; rsp_ready = 1'b1;
        req_valid3 = '0; req_x3 = '0; req_y3 = '0; req_z3 = '0; req_ctl3 = '0;
        clear_flags3 = '0; rsp_ready3 = 1'b1;

        // Reset state
        #2;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset rsp_flags", rsp_flags, 0);
        chk("reset sticky", sticky_flags, 0);
        chk("reset rsp_valid3", rsp_valid3, 0);
        tick;
        reset_n = 1'b1;

        // Single op from requester 0: 1*2+1 = 3
        set_op(0, 16'h3C00, 16'h4000, 16'h3C00, CtlFma);
        req_valid = 2'b01;
        #1 chk("t1 ready", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        chk("t1 n+1 valid", rsp_valid, 0);
        tick;
        chk("t1 valid", rsp_valid, 1);
        chk("t1 id", rsp_id, 0);
        chk("t1 result", rsp_result, 16'h4200);
        chk("t1 flags", rsp_flags, 0);
        tick;
        chk("t1 drained", rsp_valid, 0);
        chk("t1 sticky", sticky_flags, 0);

        // Both requesters streaming from reset
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        tick;
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c <= 10; c++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = (cnt[i] < 4);
                if (cnt[i] < 4) set_op(i, tbl[i*4 + cnt[i]], 16'h3C00, 16'h0, CtlPass);
            end
            #1;
            chk("t2 ready", req_ready, (c < 8) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            for (int i = 0; i < 2; i++) if (req_ready[i]) cnt[i]++;
            if (c >= 2 && c < 10) begin
                chk("t2 rsp_valid", rsp_valid, 1);
                chk("t2 rsp_id", rsp_id, (c - 2) % 2);
                chk("t2 rsp_result", rsp_result, tbl[((c - 2) % 2)*4 + (c - 2)/2]);
            end else begin
                chk("t2 rsp idle", rsp_valid, 0);
            end
            tick;
        end

        // Backpressure: requester 1 streams 3 ops while rsp_ready is low for 6 cycles
        n = 0;
        for (int b = 0; b <= 9; b++) begin
            rsp_ready = (b >= 6);
            req_valid[1] = (n < 3);
            if (n < 3) set_op(1, bp[n], 16'h3C00, 16'h0, CtlPass);
            #1;
            chk("t3 ready", req_ready, (b < 2 || b == 6) ? 2'b10 : 2'b00);
            if (req_ready[1]) n++;
            if (b < 2 || b == 9) begin
                chk("t3 rsp idle", rsp_valid, 0);
            end else begin
                chk("t3 rsp_valid", rsp_valid, 1);
                chk("t3 rsp_result", rsp_result, (b <= 6) ? bp[0] : ((b == 7) ? bp[1] : bp[2]));
            end
            tick;
        end
        chk("t3 accepted", n, 3);

        // Overflow and sticky flags on requester 1
        rsp_ready = 1'b1;
        set_op(1, 16'h7BFF, 16'h7BFF, 16'h0, CtlMulO);
        req_valid = 2'b10;
        #1 chk("t4 ready", req_ready, 2'b10);
        tick;
        req_valid = 2'b00;
        tick;
        chk("t4 ovf id", rsp_id, 1);
        chk("t4 ovf result", rsp_result, 16'h7C00);
        chk("t4 ovf flags", rsp_flags, 4'b0101);
        tick;
        chk("t4 sticky ovf", sticky_flags, 8'h50);
        set_op(1, 16'h3C00, 16'h3C00, 16'h0001, CtlFma);
        req_valid = 2'b10;
        tick;
        req_valid = 2'b00;
        tick;
        chk("t4 nx result", rsp_result, 16'h3C00);
        chk("t4 nx flags", rsp_flags, 4'b0001);
        clear_flags = 2'b10;
        tick;
        clear_flags = 2'b00;
        chk("t4 sticky clear+set", sticky_flags, 8'h10);
        clear_flags = 2'b10;
        tick;
        clear_flags = 2'b00;
        chk("t4 sticky clear", sticky_flags, 8'h00);

        // Reset with both stages full
        rsp_ready = 1'b0;
        set_op(0, 16'h5000, 16'h3C00, 16'h0, CtlPass);
        req_valid = 2'b01;
        #1 chk("t5 ready a", req_ready, 2'b01);
        tick;
        set_op(0, 16'h5100, 16'h3C00, 16'h0, CtlPass);
        #1 chk("t5 ready b", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        chk("t5 full valid", rsp_valid, 1);
        chk("t5 full result", rsp_result, 16'h5000);
        #2 reset_n = 1'b0;
        #1;
        chk("t5 async valid", rsp_valid, 0);
        chk("t5 async result", rsp_result, 0);
        tick;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        tick;
        chk("t5 no stale a", rsp_valid, 0);
        tick;
        chk("t5 no stale b", rsp_valid, 0);
        set_op(0, 16'h5200, 16'h3C00, 16'h0, CtlPass);
        set_op(1, 16'h5300, 16'h3C00, 16'h0, CtlPass);
        req_valid = 2'b11;
        #1 chk("t5 first grant", req_ready, 2'b01);
        tick;
        req_valid = 2'b10;
        #1 chk("t5 second grant", req_ready, 2'b10);
        tick;
        req_valid = 2'b00;
        chk("t5 rsp0 id", rsp_id, 0);
        chk("t5 rsp0 result", rsp_result, 16'h5200);
        tick;
        chk("t5 rsp1 id", rsp_id, 1);
        chk("t5 rsp1 result", rsp_result, 16'h5300);
        tick;
        chk("t5 drained", rsp_valid, 0);

        // Three requesters: 0 and 2 busy, 1 joins at cycle 4
        v1 = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (c == 4) v1 = 1'b1;
            req_valid3 = {(c < 7), v1, (c < 7)};
            for (int i = 0; i < 3; i++) begin
                req_x3[i*16 +: 16] = 16'h4000 + 16'(c);
                req_y3[i*16 +: 16] = 16'h3C00;
                req_ctl3[i*6 +: 6] = CtlPass;
            end
            #1;
            chk("t6 ready3", req_ready3,
                (c < 7) ? (3'b001 << g3[c]) : 3'b000);
            if (req_ready3[1]) v1 = 1'b0;
            if (c >= 2 && c < 9) begin
                chk("t6 rsp_valid3", rsp_valid3, 1);
                chk("t6 rsp_id3", rsp_id3, g3[c-2]);
            end else begin
                chk("t6 rsp idle3", rsp_valid3, 0);
            end
            tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma16_sched.md
# fma16_sched

Shared-issue scheduler for the fma16 datapath. It arbitrates round-robin among NREQ requesters, each with a valid/ready request channel, and sequences granted operations through one fma16 instance. The instance is wrapped in a two-stage register pipeline: operand register, then result register. Results return on a single tagged response channel. Per-requester sticky exception flags are kept, fcsr-style, above the shared half-precision FMA unit.

## Interface
Parameters:
- NREQ, 2, number of requesters (≥2); IDW = $clog2(NREQ)

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle
- req_x, req_y, req_z  in  16*NREQ each  packed operands; slice i belongs to requester i
- req_ctl  in  6*NREQ  per requester {mul, add, negp, negz, roundmode[1:0]}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester index of the response
- rsp_result  out  16  fma16 result
- rsp_flags  out  4  {NV, OF, UF, NX} of this operation
- clear_flags  in  NREQ  clears the sticky flags of requester i
- sticky_flags  out  4*NREQ  accumulated flags per requester

## Operation
- Arbitration:
  - Pointer `last` (IDW bits) holds the last granted index.
  - The candidate is the first valid requester scanning last+1, last+2, … mod NREQ.
  - `last` updates only on an accepted request, i.e. req_valid[i] & req_ready[i].
  - At most one req_ready bit is set per cycle.
  - req_ready[i] = (i == candidate) & req_valid[i] & s1_load.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
  - Once asserted, valid and payload must hold until accepted. The block does not check this.
- Stage 1 (operand register): s1_valid, s1_id, x, y, z, ctl.
  - s1_load = ~s1_valid | s2_load.
  - On load, capture the granted request. If nothing is granted, s1_valid ← 0.
- fma16 (combinational) is driven from the stage-1 registers only.
- Stage 2 (result register): s2_valid, s2_id, result, flags.
  - s2_load = ~s2_valid | rsp_ready.
  - On load, capture the fma16 outputs and s1_id, with s2_valid ← s1_valid.
- rsp_* outputs are driven directly from the stage-2 registers.
- Sticky flags:
  - On a response handshake (rsp_valid & rsp_ready), sticky[rsp_id] |= rsp_flags.
  - clear_flags[i] zeroes sticky[i].
  - Clear and set in the same cycle for the same i: result = rsp_flags (the set wins over old state, the clear wipes old state).
- Ordering: responses leave in acceptance order. There is no reordering and no drop.

## Timing
- Reset (asynchronous, reset_n low), all held while low:
  - s1_valid = s2_valid = 0
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0
  - sticky = 0
  - last = NREQ-1, so requester 0 wins first
- Reset mid-operation: in-flight operations are discarded and no response is produced for them.
- Latency:
  - Accepted in cycle n → rsp_valid in cycle n+2 when rsp_ready is held high.
  - Throughput 1 op/cycle with rsp_ready high.
- Full condition:
  - With rsp_ready low, both stages fill after 2 accepts.
  - Then req_ready = 0 for all requesters until rsp_ready returns.
  - The cycle rsp_ready rises, both stages advance and one new request is accepted (full-throughput bubble-free drain).
- Empty pipe: req_ready for the candidate is asserted combinationally in the same cycle as req_valid.
- Simultaneous requests: grants alternate strictly. Under continuous requests each requester gets 1 of every NREQ grants.
- No combinational path from rsp_ready to rsp_* data. A path from rsp_ready to req_ready exists through s2_load/s1_load and is permitted.

## Structure
- Shared package fma16_sched_pkg:
  - ctl field offsets
  - flag bit indices (NV=3, OF=2, UF=1, NX=0)
  - stage-1 and stage-2 packed struct typedefs
- Sub-module fma16_rr_arb: round-robin candidate/pointer logic, parameterized by NREQ.
- The existing fma16 is instantiated once, unchanged.

## Test plan
- Single op, requester 0: x=0x3C00, y=0x4000, z=0x3C00, mul=add=1, RNE → 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x4200, rsp_flags=0.
- Both requesters valid from reset with 4 ops each, rsp_ready=1 → accept order 0,1,0,1,…; responses with rsp_id 0,1,0,1; one response per cycle after 2-cycle fill.
- Backpressure: rsp_ready=0 for 6 cycles while requester 1 streams 3 ops → exactly 2 accepted, req_ready=0 thereafter, rsp payload stable; rsp_ready=1 → all 3 results in order, no loss.
- Overflow with sticky flags: requester 1, x=y=0x7BFF, mul=1, add=0, RNE → rsp_result=0x7C00, rsp_flags=4'b0101, sticky[1]=0101. clear_flags[1] pulsed alone → sticky[1]=0. Clear coincident with a 0001 response → sticky[1]=0001.
- Reset mid-operation: reset_n low with both stages valid → rsp_valid=0 immediately (asynchronous). After release, no stale response appears and requester 0 wins the first grant.
- NREQ=3 build: requesters 0 and 2 continuously valid, 1 idle → grants alternate 0,2,0,2; requester 1 then asserts → it is granted within 2 grants.
